// File: rtl/sha256_compress_core.sv
// SHA-256/224 compression engine: consumes ROUNDS_PER_CYCLE schedule words per beat, chains H.
// Define SHA224_EN to enable the SHA-224 IV (mode=1) and truncated digest output.
module sha256_compress_core #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            first_blk,
   input  logic                            mode,
   input  logic                            w_valid,
   output logic                            w_ready,
   input  logic [32*ROUNDS_PER_CYCLE-1:0]  w_data,
   output logic                            busy,
   output logic                            hash_valid,
   output logic [255:0]                    hash_out
);

   localparam int unsigned R = ROUNDS_PER_CYCLE;
   localparam logic [5:0] LastCtr = 6'(64 - R);
   localparam logic [5:0] CtrInc = 6'(R);

   if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : gen_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [255:0] Iv256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // One FIPS 180-4 round on packed {a,b,c,d,e,f,g,h}, a in the top word.
   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                              input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   state_e        state_q, state_d;
   logic [5:0]    ctr_q, ctr_d;
   logic [255:0]  h_q, h_d;
   logic [255:0]  v_q, v_d;
   logic          hv_q, hv_d;
   logic [255:0]  iv;
   logic [255:0]  h_new;
   logic [255:0]  rnd;
   logic [5:0]    k_idx;

`ifdef SHA224_EN
   localparam logic [255:0] Iv224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   logic mode_q, mode_d;

   assign iv = mode ? Iv224 : Iv256;

   always_comb begin
      mode_d = mode_q;
      if (state_q == StIdle && start && first_blk) begin
         mode_d = mode;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
      end
   end

   // H7 stays intact internally so a SHA-224 message can keep chaining.
   assign hash_out = mode_q ? {h_q[255:32], 32'h0} : h_q;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign iv = Iv256;
   assign hash_out = h_q;
`endif

   always_comb begin
      rnd = v_q;
      k_idx = '0;
      for (int j = 0; j < int'(R); j++) begin
         k_idx = ctr_q + 6'(j);
         rnd = sha_round(rnd, K[k_idx], w_data[32*j +: 32]);
      end
   end

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      h_d     = h_q;
      v_d     = v_q;
      hv_d    = hv_q;
      h_new   = first_blk ? iv : h_q;
      w_ready = 1'b0;
      busy    = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               h_d     = h_new;
               v_d     = h_new;
               ctr_d   = '0;
               hv_d    = 1'b0;
               state_d = StRound;
            end
         end
         StRound: begin
            w_ready = 1'b1;
            busy    = 1'b1;
            if (w_valid) begin
               v_d   = rnd;
               ctr_d = ctr_q + CtrInc;
               if (ctr_q == LastCtr) begin
                  state_d = StFinal;
               end
            end
         end
         StFinal: begin
            busy = 1'b1;
            for (int i = 0; i < 8; i++) begin
               h_d[32*i +: 32] = h_q[32*i +: 32] + v_q[32*i +: 32];
            end
            hv_d    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ctr_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         hv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         h_q     <= h_d;
         v_q     <= v_d;
         hv_q    <= hv_d;
      end
   end

   assign hash_valid = hv_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Bench for sha256_compress_core: one instance per R in {1,2,4,8}, checked every cycle against a
// plain SHA-256 model; known digests pin the model. Honours SHA224_EN like the design.
module tb_sha256_compress_core;

   typedef logic [31:0] word_t;
   localparam int NI = 4;

   localparam logic [255:0] T1_DIG =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] T2_DIG =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA224_EN
   localparam logic [223:0] T3_HI =
      224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7;
`endif

   localparam word_t KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0]        rst, start, first_blk, mode, w_valid;
   logic [NI-1:0]        w_ready, busy, hash_valid;
   logic [NI-1:0][255:0] w_data;
   logic [NI-1:0][255:0] hash_out;

   for (genvar g = 0; g < NI; g++) begin : gen_dut
      localparam int unsigned RG = 1 << g;
      sha256_compress_core #(.ROUNDS_PER_CYCLE(RG)) u_dut (
         .clk        (clk),
         .rst        (rst[g]),
         .start      (start[g]),
         .first_blk  (first_blk[g]),
         .mode       (mode[g]),
         .w_valid    (w_valid[g]),
         .w_ready    (w_ready[g]),
         .w_data     (w_data[g][32*RG-1:0]),
         .busy       (busy[g]),
         .hash_valid (hash_valid[g]),
         .hash_out   (hash_out[g])
      );
   end

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cur = 0;
   bit           chk_en = 1'b0;
   logic         exp_ready, exp_busy, exp_hv;
   logic [255:0] exp_hash;
   logic [255:0] m_h [NI];
   bit           m_mode [NI];
   word_t        blk_m [16];
   word_t        sched [64];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, cur, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("w_ready", 256'(w_ready[cur]), 256'(exp_ready));
         check("busy", 256'(busy[cur]), 256'(exp_busy));
         check("hash_valid", 256'(hash_valid[cur]), 256'(exp_hv));
         check("hash_out", hash_out[cur], exp_hash);
      end
   end

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void expand();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) sched[t] = blk_m[t];
         else sched[t] = (rotr(sched[t-2], 17) ^ rotr(sched[t-2], 19) ^ (sched[t-2] >> 10))
                        + sched[t-7]
                        + (rotr(sched[t-15], 7) ^ rotr(sched[t-15], 18) ^ (sched[t-15] >> 3))
                        + sched[t-16];
      end
   endfunction

   function automatic logic [255:0] model_compress(input logic [255:0] hin);
      word_t v [8];
      word_t t1, t2;
      logic [255:0] res;
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + sched[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return res;
   endfunction

   function automatic logic [255:0] iv_of(input bit md);
`ifdef SHA224_EN
      if (md) return 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif
      return 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   endfunction

   function automatic logic [255:0] visible(input int idx, input logic [255:0] h);
`ifdef SHA224_EN
      if (m_mode[idx]) return {h[255:32], 32'h0};
`endif
      return h;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_reset_exp(input int idx);
      m_h[idx] = '0;
      m_mode[idx] = 1'b0;
      exp_ready = 1'b0;
      exp_busy = 1'b0;
      exp_hv = 1'b0;
      exp_hash = '0;
   endtask

   task automatic do_reset(input int idx);
      rst[idx] = 1'b1;
      tick();
      rst[idx] = 1'b0;
      set_idle_reset_exp(idx);
   endtask

   function automatic void load_words(input word_t w0, input word_t w15);
      for (int i = 0; i < 16; i++) blk_m[i] = '0;
      blk_m[0] = w0;
      blk_m[15] = w15;
      expand();
   endfunction

   function automatic void load_t2_first();
      word_t b;
      b = 32'h61626364;
      for (int i = 0; i < 14; i++) blk_m[i] = b + 32'h01010101 * word_t'(i);
      blk_m[14] = 32'h80000000;
      blk_m[15] = 32'h0;
      expand();
   endfunction

   // Runs one block; gap_pct = percent of cycles with w_valid low, rst_beat < 0 means no abort.
   task automatic run_block(input int idx, input bit first, input bit md, input int gap_pct,
                            input bit pulse_start, input int rst_beat);
      int r, nb, beat, cyc;
      logic [255:0] hnew, dig;
      r = 1 << idx;
      nb = 64 / r;
      beat = 0;
      cyc = 0;
      if (first) begin
`ifdef SHA224_EN
         m_mode[idx] = md;
`endif
         hnew = iv_of(md);
      end else begin
         hnew = m_h[idx];
      end
      dig = model_compress(hnew);
      start[idx] = 1'b1;
      first_blk[idx] = first;
      mode[idx] = md;
      tick();
      start[idx] = 1'b0;
      m_h[idx] = hnew;
      exp_ready = 1'b1;
      exp_busy = 1'b1;
      exp_hv = 1'b0;
      exp_hash = visible(idx, hnew);
      while (beat < nb) begin
         if (beat == rst_beat) begin
            w_valid[idx] = 1'b0;
            do_reset(idx);
            return;
         end
         w_valid[idx] = (cyc > 3 * nb) || (int'($urandom_range(99)) >= gap_pct);
         for (int j = 0; j < 8; j++) w_data[idx][32*j +: 32] = $urandom;
         if (w_valid[idx]) begin
            for (int j = 0; j < r; j++) w_data[idx][32*j +: 32] = sched[beat*r + j];
         end
         if (pulse_start && beat == 2) begin
            start[idx] = 1'b1;
            first_blk[idx] = 1'b1;
            mode[idx] = 1'($urandom_range(1));
         end
         tick();
         cyc++;
         start[idx] = 1'b0;
         if (w_valid[idx]) beat++;
         if (beat == nb) exp_ready = 1'b0;
      end
      w_valid[idx] = 1'b0;
      tick();
      m_h[idx] = dig;
      exp_busy = 1'b0;
      exp_hv = 1'b1;
      exp_hash = visible(idx, dig);
   endtask

   task automatic idle_cycles(input int idx, input int n);
      for (int i = 0; i < n; i++) begin
         w_valid[idx] = 1'($urandom_range(1));
         w_data[idx] = {8{$urandom}};
         tick();
      end
      w_valid[idx] = 1'b0;
   endtask

   task automatic run_scenarios(input int idx);
      int rb;
      rb = (64 / (1 << idx) > 10) ? 10 : 64 / (1 << idx) / 2;
      load_words(32'h61626380, 32'h00000018);
      check("model_abc", model_compress(iv_of(1'b0)), T1_DIG);
      run_block(idx, 1'b1, 1'b0, 0, 1'b0, -1);
      check("t1_digest", hash_out[idx], T1_DIG);
      idle_cycles(idx, 3);
      load_t2_first();
      run_block(idx, 1'b1, 1'b0, 0, 1'b0, -1);
      load_words(32'h0, 32'h000001c0);
      run_block(idx, 1'b0, 1'b0, 0, 1'b0, -1);
      check("t2_digest", hash_out[idx], T2_DIG);
      load_words(32'h61626380, 32'h00000018);
      run_block(idx, 1'b1, 1'b1, 0, 1'b0, -1);
`ifdef SHA224_EN
      check("t3_digest", hash_out[idx], {T3_HI, 32'h0});
`else
      check("t3_mode_ignored", hash_out[idx], T1_DIG);
`endif
      run_block(idx, 1'b1, 1'b0, 50, 1'b0, -1);
      check("t4_gaps_digest", hash_out[idx], T1_DIG);
      run_block(idx, 1'b1, 1'b0, 0, 1'b1, -1);
      check("t5_restart_digest", hash_out[idx], T1_DIG);
      idle_cycles(idx, 2);
      run_block(idx, 1'b1, 1'b0, 0, 1'b0, rb);
      check("t6_rst_hash", hash_out[idx], 256'h0);
      check("t6_rst_busy", 256'(busy[idx]), 256'h0);
      run_block(idx, 1'b1, 1'b0, 0, 1'b0, -1);
      check("t6_fresh_digest", hash_out[idx], T1_DIG);
      do_reset(idx);
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
         expand();
         run_block(idx, (k == 0) ? 1'b0 : 1'($urandom_range(1)), 1'($urandom_range(1)), 30,
                   k == 2, -1);
         idle_cycles(idx, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = '1;
      start = '0;
      first_blk = '0;
      mode = '0;
      w_valid = '0;
      w_data = '0;
      repeat (3) tick();
      rst = '0;
      for (int i = 0; i < NI; i++) begin
         cur = i;
         check("reset_w_ready", 256'(w_ready[i]), 256'h0);
         check("reset_busy", 256'(busy[i]), 256'h0);
         check("reset_hash_valid", 256'(hash_valid[i]), 256'h0);
         check("reset_hash_out", hash_out[i], 256'h0);
      end
      for (int i = 0; i < NI; i++) begin
         cur = i;
         set_idle_reset_exp(i);
         chk_en = 1'b1;
         run_scenarios(i);
         chk_en = 1'b0;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
